// File: rtl/tx_intf_m_axis_pkt.sv
// AXI4-Stream packet master for the tx_intf DMA path: FWFT FIFO buffering accelerator words,
// start-delayed packet streaming with partial last-beat TKEEP, abort/flush and status monitors.
`timescale 1ns/1ps
module tx_intf_m_axis_pkt #(
  parameter int C_M_AXIS_TDATA_WIDTH   = 64,
  parameter int FIFO_ADDR_BITS         = 6,
  parameter int WAIT_COUNT_BITS        = 5,
  parameter int MAX_BIT_NUM_DMA_SYMBOL = 14,
  parameter int STAT_BITS              = 16
) (
  input  logic                                M_AXIS_ACLK,
  input  logic                                M_AXIS_ARESETN,
  input  logic                                start_1trans,
  input  logic                                abort_trans,
  input  logic                                endless_mode,
  input  logic [WAIT_COUNT_BITS-1:0]          START_COUNT_CFG,
  input  logic [MAX_BIT_NUM_DMA_SYMBOL-1:0]   M_AXIS_NUM_DMA_SYMBOL,
  input  logic [C_M_AXIS_TDATA_WIDTH/8-1:0]   LAST_BEAT_KEEP,
  input  logic [C_M_AXIS_TDATA_WIDTH-1:0]     DATA_FROM_ACC,
  input  logic                                ACC_DATA_READY,
  output logic                                FULLN_TO_ACC,
  output logic [FIFO_ADDR_BITS:0]             data_count,
  output logic                                tx_busy,
  output logic                                tx_done_pulse,
  output logic [STAT_BITS-1:0]                underrun_count,
  output logic                                overflow_sticky,
  output logic                                M_AXIS_TVALID,
  output logic [C_M_AXIS_TDATA_WIDTH-1:0]     M_AXIS_TDATA,
  output logic [C_M_AXIS_TDATA_WIDTH/8-1:0]   M_AXIS_TKEEP,
  output logic [C_M_AXIS_TDATA_WIDTH/8-1:0]   M_AXIS_TSTRB,
  output logic                                M_AXIS_TLAST,
  input  logic                                M_AXIS_TREADY
);

  localparam int DEPTH = 1 << FIFO_ADDR_BITS;
  localparam logic [FIFO_ADDR_BITS:0] FULL_CNT = (FIFO_ADDR_BITS+1)'(DEPTH);

  typedef enum logic [1:0] {IDLE, WAIT_START, SEND} state_t;

  state_t                              state, state_nxt;
  logic [C_M_AXIS_TDATA_WIDTH-1:0]     mem [DEPTH];
  logic [FIFO_ADDR_BITS-1:0]           wr_ptr, rd_ptr;
  logic [WAIT_COUNT_BITS-1:0]          wait_cnt;
  logic [MAX_BIT_NUM_DMA_SYMBOL-1:0]   beat_cnt;
  logic                                start_q, start_pulse, start_ok;
  logic                                empty, full, wr_en, rd_en, handshake, last_hs;

  assign empty        = (data_count == '0);
  assign full         = (data_count == FULL_CNT);
  assign FULLN_TO_ACC = ~full;
  assign tx_busy      = (state != IDLE);
  assign start_pulse  = start_1trans & ~start_q;
  assign start_ok     = (state == IDLE) & start_pulse & ~abort_trans;
  assign handshake    = M_AXIS_TVALID & M_AXIS_TREADY;
  assign last_hs      = handshake & M_AXIS_TLAST;
  assign wr_en        = ACC_DATA_READY & ~full & ~abort_trans;
  assign rd_en        = handshake & ~abort_trans;

  always_comb begin
    M_AXIS_TVALID = (state == SEND) & ~empty;
    M_AXIS_TLAST  = M_AXIS_TVALID & ~endless_mode & (beat_cnt == M_AXIS_NUM_DMA_SYMBOL);
    M_AXIS_TKEEP  = M_AXIS_TLAST ? LAST_BEAT_KEEP : '1;
    M_AXIS_TSTRB  = M_AXIS_TKEEP;
    M_AXIS_TDATA  = empty ? '0 : mem[rd_ptr];
  end

  // NOTE: storage has no reset; TDATA is forced to zero while the FIFO is empty, so stale
  // contents are never visible and the array can map onto plain RAM.
  always_ff @(posedge M_AXIS_ACLK) begin
    if (wr_en) mem[wr_ptr] <= DATA_FROM_ACC;
  end

  // NOTE: every clocked process uses non-blocking assignments so all registers see
  // pre-edge values regardless of process evaluation order.
  always_ff @(posedge M_AXIS_ACLK or negedge M_AXIS_ARESETN) begin
    if (!M_AXIS_ARESETN) begin
      wr_ptr     <= '0;
      rd_ptr     <= '0;
      data_count <= '0;
    end else if (abort_trans) begin
      wr_ptr     <= '0;
      rd_ptr     <= '0;
      data_count <= '0;
    end else begin
      if (wr_en) wr_ptr <= wr_ptr + 1'b1;
      if (rd_en) rd_ptr <= rd_ptr + 1'b1;
      case ({wr_en, rd_en})
        2'b10:   data_count <= data_count + 1'b1;
        2'b01:   data_count <= data_count - 1'b1;
        default: data_count <= data_count;
      endcase
    end
  end

  // NOTE: next-state defaults to the current state first, so no path leaves it unassigned
  // and no latch is inferred.
  always_comb begin
    state_nxt = state;
    if (abort_trans) begin
      state_nxt = IDLE;
    end else begin
      case (state)
        IDLE:       if (start_pulse) state_nxt = WAIT_START;
        WAIT_START: if (wait_cnt == START_COUNT_CFG) state_nxt = SEND;
        SEND:       if (last_hs) state_nxt = IDLE;
        default:    state_nxt = IDLE;
      endcase
    end
  end

  always_ff @(posedge M_AXIS_ACLK or negedge M_AXIS_ARESETN) begin
    if (!M_AXIS_ARESETN) begin
      state           <= IDLE;
      start_q         <= 1'b0;
      wait_cnt        <= '0;
      beat_cnt        <= '0;
      underrun_count  <= '0;
      overflow_sticky <= 1'b0;
      tx_done_pulse   <= 1'b0;
    end else begin
      state   <= state_nxt;
      start_q <= start_1trans;

      if (state != WAIT_START || wait_cnt == START_COUNT_CFG) wait_cnt <= '0;
      else                                                    wait_cnt <= wait_cnt + 1'b1;

      // Wraps naturally in endless mode.
      if (start_ok)                       beat_cnt <= '0;
      else if (state == SEND && handshake) beat_cnt <= beat_cnt + 1'b1;

      if (start_ok)                                          underrun_count <= '0;
      else if (state == SEND && empty && underrun_count != '1) underrun_count <= underrun_count + 1'b1;

      if (ACC_DATA_READY && full) overflow_sticky <= 1'b1;

      tx_done_pulse <= (state == SEND) & last_hs & ~abort_trans;
    end
  end

endmodule

// File: tb/tb_tx_intf_m_axis_pkt.sv
// Directed bench for tx_intf_m_axis_pkt: latency, underrun, back-pressure, overflow,
// endless streaming with abort, single-beat packets, start/abort collision and async reset.
`timescale 1ns/1ps
module tb_tx_intf_m_axis_pkt;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        start_1trans, abort_trans, endless_mode;
  logic [4:0]  START_COUNT_CFG;
  logic [13:0] M_AXIS_NUM_DMA_SYMBOL;
  logic [7:0]  LAST_BEAT_KEEP;
  logic [63:0] DATA_FROM_ACC;
  logic        ACC_DATA_READY;
  logic        FULLN_TO_ACC;
  logic [6:0]  data_count;
  logic        tx_busy, tx_done_pulse;
  logic [15:0] underrun_count;
  logic        overflow_sticky;
  logic        M_AXIS_TVALID, M_AXIS_TLAST, M_AXIS_TREADY;
  logic [63:0] M_AXIS_TDATA;
  logic [7:0]  M_AXIS_TKEEP, M_AXIS_TSTRB;

  tx_intf_m_axis_pkt dut (
    .M_AXIS_ACLK(clk), .M_AXIS_ARESETN(rst_n),
    .start_1trans(start_1trans), .abort_trans(abort_trans), .endless_mode(endless_mode),
    .START_COUNT_CFG(START_COUNT_CFG), .M_AXIS_NUM_DMA_SYMBOL(M_AXIS_NUM_DMA_SYMBOL),
    .LAST_BEAT_KEEP(LAST_BEAT_KEEP), .DATA_FROM_ACC(DATA_FROM_ACC),
    .ACC_DATA_READY(ACC_DATA_READY), .FULLN_TO_ACC(FULLN_TO_ACC), .data_count(data_count),
    .tx_busy(tx_busy), .tx_done_pulse(tx_done_pulse), .underrun_count(underrun_count),
    .overflow_sticky(overflow_sticky), .M_AXIS_TVALID(M_AXIS_TVALID),
    .M_AXIS_TDATA(M_AXIS_TDATA), .M_AXIS_TKEEP(M_AXIS_TKEEP), .M_AXIS_TSTRB(M_AXIS_TSTRB),
    .M_AXIS_TLAST(M_AXIS_TLAST), .M_AXIS_TREADY(M_AXIS_TREADY)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [63:0] data;
    logic [7:0]  keep;
    logic        last;
  } beat_t;

  beat_t       beats[$];
  int          checks = 0;
  int          failures = 0;
  int          beat_total = 0;
  int          tlast_cnt = 0;
  int          done_cnt = 0;
  logic        chk_stable = 1'b0;
  logic        pend = 1'b0;
  logic [63:0] pend_data = '0;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic write_word(input logic [63:0] d);
    ACC_DATA_READY = 1'b1;
    DATA_FROM_ACC  = d;
    tick();
    ACC_DATA_READY = 1'b0;
  endtask

  task automatic wait_done(input int budget, output int n);
    n = 0;
    do begin
      tick();
      n++;
    end while (!tx_done_pulse && n < budget);
    check("done_seen", 64'(tx_done_pulse), 64'd1);
  endtask

  task automatic check_beats(input string tag, input int n, input logic [63:0] base,
                             input logic [7:0] keep);
    check({tag, "_count"}, 64'(beats.size()), 64'(n));
    for (int i = 0; i < n && i < beats.size(); i++) begin
      check({tag, "_data"}, beats[i].data, base + 64'(i));
      check({tag, "_last"}, 64'(beats[i].last), 64'(i == n - 1));
      check({tag, "_keep"}, 64'(beats[i].keep), (i == n - 1) ? 64'(keep) : 64'hFF);
    end
    beats.delete();
  endtask

  task automatic check_reset_vals(input string tag);
    check({tag, "_tvalid"}, 64'(M_AXIS_TVALID), 64'd0);
    check({tag, "_tlast"},  64'(M_AXIS_TLAST), 64'd0);
    check({tag, "_tdata"},  M_AXIS_TDATA, 64'd0);
    check({tag, "_tkeep"},  64'(M_AXIS_TKEEP), 64'hFF);
    check({tag, "_tstrb"},  64'(M_AXIS_TSTRB), 64'hFF);
    check({tag, "_busy"},   64'(tx_busy), 64'd0);
    check({tag, "_done"},   64'(tx_done_pulse), 64'd0);
    check({tag, "_count"},  64'(data_count), 64'd0);
    check({tag, "_fulln"},  64'(FULLN_TO_ACC), 64'd1);
    check({tag, "_underrun"}, 64'(underrun_count), 64'd0);
    check({tag, "_overflow"}, 64'(overflow_sticky), 64'd0);
  endtask

  // Beats are captured on the falling edge, ahead of the rising edge that completes them.
  always @(negedge clk) begin
    if (rst_n) begin
      if (chk_stable && pend) begin
        check("hold_tvalid", 64'(M_AXIS_TVALID), 64'd1);
        check("hold_tdata", M_AXIS_TDATA, pend_data);
      end
      pend      = M_AXIS_TVALID && !M_AXIS_TREADY;
      pend_data = M_AXIS_TDATA;
      if (M_AXIS_TVALID && M_AXIS_TREADY) begin
        beats.push_back('{data: M_AXIS_TDATA, keep: M_AXIS_TKEEP, last: M_AXIS_TLAST});
        beat_total++;
      end
      if (M_AXIS_TLAST) tlast_cnt++;
      if (tx_done_pulse) done_cnt++;
    end
  end

  initial begin
    int n;
    int b0, t0, d0;

    rst_n = 1'b0;
    start_1trans = 1'b0; abort_trans = 1'b0; endless_mode = 1'b0;
    START_COUNT_CFG = '0; M_AXIS_NUM_DMA_SYMBOL = '0; LAST_BEAT_KEEP = '0;
    DATA_FROM_ACC = '0; ACC_DATA_READY = 1'b0; M_AXIS_TREADY = 1'b0;
    repeat (3) tick();
    check_reset_vals("rst_in");
    rst_n = 1'b1;
    tick();
    check_reset_vals("rst_out");

    // 1: preloaded 4-beat packet with a 4-cycle start delay
    START_COUNT_CFG = 5'd3; M_AXIS_NUM_DMA_SYMBOL = 14'd3; LAST_BEAT_KEEP = 8'h0F;
    for (int i = 0; i < 4; i++) write_word(64'h1000 + 64'(i));
    check("t1_preload_count", 64'(data_count), 64'd4);
    check("t1_fwft_head", M_AXIS_TDATA, 64'h1000);
    M_AXIS_TREADY = 1'b1;
    start_1trans = 1'b1;
    n = 0;
    do begin
      tick();
      n++;
      if (n == 1) check("t1_busy", 64'(tx_busy), 64'd1);
    end while (!M_AXIS_TVALID && n < 20);
    check("t1_latency", 64'(n), 64'd5);
    wait_done(20, n);
    check("t1_done_delay", 64'(n), 64'd4);
    tick();
    check("t1_done_width", 64'(tx_done_pulse), 64'd0);
    check("t1_idle", 64'(tx_busy), 64'd0);
    check_beats("t1", 4, 64'h1000, 8'h0F);
    start_1trans = 1'b0;
    tick();

    // 2: slow writer, 8-beat packet, expect underruns
    START_COUNT_CFG = 5'd0; M_AXIS_NUM_DMA_SYMBOL = 14'd7; LAST_BEAT_KEEP = 8'h03;
    start_1trans = 1'b1;
    fork
      for (int i = 0; i < 8; i++) begin
        write_word(64'h2000 + 64'(i));
        tick();
        tick();
      end
      wait_done(200, n);
    join
    check("t2_underrun_nz", 64'(underrun_count != 0), 64'd1);
    check_beats("t2", 8, 64'h2000, 8'h03);
    start_1trans = 1'b0;
    tick();

    // 3: random back-pressure, 16-beat packet
    START_COUNT_CFG = 5'd1; M_AXIS_NUM_DMA_SYMBOL = 14'd15; LAST_BEAT_KEEP = 8'hF0;
    for (int i = 0; i < 16; i++) write_word(64'h3000 + 64'(i));
    chk_stable = 1'b1;
    start_1trans = 1'b1;
    n = 0;
    do begin
      M_AXIS_TREADY = 1'($urandom_range(0, 1));
      tick();
      n++;
    end while (!tx_done_pulse && n < 500);
    check("t3_done_seen", 64'(tx_done_pulse), 64'd1);
    chk_stable = 1'b0;
    M_AXIS_TREADY = 1'b1;
    check("t3_underrun", 64'(underrun_count), 64'd0);
    check_beats("t3", 16, 64'h3000, 8'hF0);
    start_1trans = 1'b0;
    tick();

    // 4: fill the FIFO, overflow by one, then stream all 64 words
    for (int i = 0; i < 64; i++) write_word(64'h4000 + 64'(i));
    check("t4_full_count", 64'(data_count), 64'd64);
    check("t4_fulln", 64'(FULLN_TO_ACC), 64'd0);
    check("t4_ovf_before", 64'(overflow_sticky), 64'd0);
    write_word(64'hDEAD);
    check("t4_ovf_after", 64'(overflow_sticky), 64'd1);
    check("t4_count_held", 64'(data_count), 64'd64);
    START_COUNT_CFG = 5'd0; M_AXIS_NUM_DMA_SYMBOL = 14'd63; LAST_BEAT_KEEP = 8'h3C;
    start_1trans = 1'b1;
    wait_done(200, n);
    check_beats("t4", 64, 64'h4000, 8'h3C);
    check("t4_drained", 64'(data_count), 64'd0);
    start_1trans = 1'b0;
    tick();

    // 5: endless stream of 3*2**14 beats, then abort
    endless_mode = 1'b1; M_AXIS_NUM_DMA_SYMBOL = 14'd0;
    b0 = beat_total; t0 = tlast_cnt; d0 = done_cnt;
    start_1trans = 1'b1;
    ACC_DATA_READY = 1'b1;
    n = 0;
    do begin
      DATA_FROM_ACC = 64'h5000_0000 + 64'(n);
      tick();
      n++;
    end while ((beat_total - b0) < 49152 && n < 60000);
    beats.delete();
    check("t5_beats", 64'((beat_total - b0) >= 49152), 64'd1);
    check("t5_busy", 64'(tx_busy), 64'd1);
    abort_trans = 1'b1;
    tick();
    check("t5_abort_tvalid", 64'(M_AXIS_TVALID), 64'd0);
    check("t5_abort_tlast", 64'(M_AXIS_TLAST), 64'd0);
    check("t5_abort_count", 64'(data_count), 64'd0);
    check("t5_abort_idle", 64'(tx_busy), 64'd0);
    abort_trans = 1'b0;
    ACC_DATA_READY = 1'b0;
    tick();
    check("t5_post_count", 64'(data_count), 64'd0);
    check("t5_no_tlast", 64'(tlast_cnt - t0), 64'd0);
    check("t5_no_done", 64'(done_cnt - d0), 64'd0);
    endless_mode = 1'b0;
    start_1trans = 1'b0;
    beats.delete();
    tick();

    // 6a: single-beat packet
    START_COUNT_CFG = 5'd2; M_AXIS_NUM_DMA_SYMBOL = 14'd0; LAST_BEAT_KEEP = 8'h01;
    write_word(64'h6000);
    start_1trans = 1'b1;
    wait_done(50, n);
    check_beats("t6", 1, 64'h6000, 8'h01);
    start_1trans = 1'b0;
    tick();

    // 6b: start edge and abort together
    start_1trans = 1'b1;
    abort_trans = 1'b1;
    tick();
    check("t6_abort_wins", 64'(tx_busy), 64'd0);
    abort_trans = 1'b0;
    tick();
    check("t6_no_late_start", 64'(tx_busy), 64'd0);
    start_1trans = 1'b0;
    tick();

    // 6c: asynchronous reset in the middle of a packet
    M_AXIS_NUM_DMA_SYMBOL = 14'd1;
    write_word(64'h7000);
    write_word(64'h7001);
    M_AXIS_TREADY = 1'b0;
    start_1trans = 1'b1;
    n = 0;
    do begin
      tick();
      n++;
    end while (!M_AXIS_TVALID && n < 20);
    check("t6_mid_tvalid", 64'(M_AXIS_TVALID), 64'd1);
    #2 rst_n = 1'b0;
    #1;
    check_reset_vals("t6_async");
    start_1trans = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    tick();
    check_reset_vals("t6_release");

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
